gc_sched_mc: RTL and testbench
==============================

# gc_sched_mc

Multi-channel garbage-collection scheduler for the NVM controller. It watches the per-channel clean-block counts and picks a victim channel by watermark priority and round-robin fairness. It then runs the GC handshake for that channel: request grant, valid-page moves and block clean. Optionally, it pauses between page moves to let host writes through. It sits between the flash channel bookkeeping and the host/GC arbiter.

## Interface
- NUM_CH, 4: number of flash channels; must be >= 2. Localparam CH_W = $clog2(NUM_CH).
- CNT_W, 4: width of each per-channel clean-block count.
- PAGE_W, 6: width of the victim valid-page count.
- LOW_WM, 4: a channel needs background GC when clean count < LOW_WM.
- CRIT_WM, 1: a channel needs urgent GC when clean count < CRIT_WM; requires CRIT_WM <= LOW_WM.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- clean_num  in  NUM_CH*CNT_W  per-channel clean counts; channel i at [i*CNT_W +: CNT_W].
- host_req  in  1  host write pending; used only under GC_PREEMPT_EN.
- gc_start  in  1  grant for the current gc_request.
- victim_pages  in  PAGE_W  valid pages in the victim block; sampled with gc_start.
- move_done_flag  in  1  one-cycle pulse: one page move finished.
- clean_done  in  1  one-cycle pulse: block clean finished.
- gc_request  out  1  GC requesting a grant.
- gc_ch  out  CH_W  channel under GC.
- gc_urgent  out  1  current GC is urgent.
- move_flag  out  1  page move requested; held until move_done_flag.
- request_blk_clean  out  1  block clean requested; held until clean_done.
- request_done  out  1  one-cycle pulse: GC pass complete.
- gc_interrupt  out  1  GC paused for host traffic.

## Operation
- States: IDLE, REQ, MOVE, PAUSE, CLEAN, DONE. All outputs are decoded from registered state and registers (Moore).
- IDLE:
  - needy[i] = clean_num[i] < LOW_WM; crit[i] = clean_num[i] < CRIT_WM.
  - If any crit bit is set, select from crit; otherwise select from needy.
  - Selection is round-robin: search from last_ch+1 upward with wrap.
  - Latch gc_ch and gc_urgent, then go to REQ. If nothing is needy, stay in IDLE.
- REQ: gc_request=1.
  - On gc_start, load the page counter with victim_pages.
  - Go to CLEAN if victim_pages==0, else go to MOVE.
- MOVE: move_flag=1.
  - On move_done_flag, decrement the counter.
  - If the counter reaches 0, go to CLEAN.
  - Otherwise apply the preemption check (Configuration) and stay in MOVE if no pause is taken.
- PAUSE: gc_interrupt=1, move_flag=0.
  - Go to MOVE when host_req==0.
  - Also go to MOVE when clean_num[gc_ch] < CRIT_WM; in that case set gc_urgent=1.
- CLEAN: request_blk_clean=1. On clean_done, go to DONE.
- DONE:
  - request_done=1 for one cycle.
  - last_ch <= gc_ch; gc_urgent <= 0.
  - Go to IDLE.
- Stray pulses are ignored: gc_start outside REQ, move_done_flag outside MOVE, clean_done outside CLEAN.
- clean_num is sampled only in IDLE and PAUSE. Changes during the other states do not retarget the pass.
- Page counter width is PAGE_W. It never underflows because decrement happens only in MOVE with counter >= 1.

## Timing
- Reset: state=IDLE, last_ch=NUM_CH-1 (channel 0 wins first), counter=0, gc_ch=0. All outputs are 0 from the first edge with RST high.
- RST asserted in any state, including mid-MOVE and mid-CLEAN, aborts the pass. No request_done is issued.
- Needy channel visible in IDLE at edge n: gc_request=1 after edge n+1.
- gc_start sampled at edge k: gc_request=0 and move_flag=1 (or request_blk_clean=1 if victim_pages==0) after edge k.
- move_done_flag on the last page at edge k: move_flag=0 and request_blk_clean=1 after edge k.
- clean_done at edge k: request_done=1 for exactly the cycle after edge k; IDLE follows one cycle later.
- Minimum gap between two passes is 1 IDLE cycle.
- gc_start and move_done_flag asserted together in REQ: only gc_start is acted on.

## Configuration
- GC_PREEMPT_EN defined:
  - In MOVE, the preemption check is: on move_done_flag with counter still > 0, if host_req==1 and gc_urgent==0, go to PAUSE.
  - Preemption happens only at page boundaries, never while a move is in flight.
- GC_PREEMPT_EN undefined:
  - host_req is ignored and PAUSE is unreachable.
  - gc_interrupt is tied to 0.

## Test plan
- Reset, all clean_num=8 for 50 cycles: every output stays 0.
- ch2 clean_num=3, victim_pages=3 at gc_start: gc_request with gc_ch=2, gc_urgent=0. After 3 move_done_flag pulses, move_flag=0 and request_blk_clean=1. After clean_done, request_done is high for exactly 1 cycle.
- ch1=3 and ch3=0 present together: first pass has gc_ch=3, gc_urgent=1; second pass has gc_ch=1.
- ch0=2 and ch1=2 held for four passes: gc_ch sequence is 0,1,0,1. victim_pages=0 on a pass goes REQ→CLEAN with no move_flag.
- GC_PREEMPT_EN, victim_pages=4, host_req=1 at the 1st move_done_flag: gc_interrupt=1 and move_flag=0. Drop host_req: MOVE resumes and needs exactly 3 more pulses. With the macro undefined, the same stimulus produces no pause.
- RST pulsed mid-MOVE: all outputs 0 after that edge, no request_done. The next pass starts from channel 0.

Source files
------------

// File: rtl/gc_sched_mc.sv
// gc_sched_mc: multi-channel GC scheduler; picks a victim channel by
// watermark priority plus round-robin and runs its GC handshake.
// Ports: CLK, RST (sync, active-high); clean_num (per-channel counts);
// host_req; gc_start + victim_pages (grant); move_done_flag; clean_done;
// out: gc_request, gc_ch, gc_urgent, move_flag, request_blk_clean,
// request_done, gc_interrupt.
// Optional feature macro: GC_PREEMPT_EN (pause between page moves for host).
module gc_sched_mc #(
    parameter  int NUM_CH  = 4,
    parameter  int CNT_W   = 4,
    parameter  int PAGE_W  = 6,
    parameter  int LOW_WM  = 4,
    parameter  int CRIT_WM = 1,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_CH*CNT_W-1:0] clean_num,
    input  logic                    host_req,
    input  logic                    gc_start,
    input  logic [PAGE_W-1:0]       victim_pages,
    input  logic                    move_done_flag,
    input  logic                    clean_done,
    output logic                    gc_request,
    output logic [CH_W-1:0]         gc_ch,
    output logic                    gc_urgent,
    output logic                    move_flag,
    output logic                    request_blk_clean,
    output logic                    request_done,
    output logic                    gc_interrupt
);

    localparam logic [31:0] LOW_U  = LOW_WM;
    localparam logic [31:0] CRIT_U = CRIT_WM;

    typedef enum logic [2:0] {
        IDLE, REQ, MOVE, PAUSE, CLEAN, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     last_q, last_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                urg_q, urg_d;
    logic [PAGE_W-1:0]   cnt_q, cnt_d;

    logic [NUM_CH-1:0]   needy, crit, cand;
    logic                sel_found;
    logic [CH_W-1:0]     sel_ch;
    logic [CNT_W-1:0]    cur_clean;
    logic                cur_crit;
    logic                preempt;

    // Watermark classification and round-robin pick starting after last_q.
    always_comb begin
        needy     = '0;
        crit      = '0;
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            needy[i] = 32'(clean_num[i*CNT_W +: CNT_W]) < LOW_U;
            crit[i]  = 32'(clean_num[i*CNT_W +: CNT_W]) < CRIT_U;
        end
        cand = (|crit) ? crit : needy;
        for (int k = 1; k <= NUM_CH; k++) begin
            int j;
            j = int'(last_q) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!sel_found && cand[j]) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(j);
            end
        end
    end

    // Clean count of the channel currently under GC (checked while paused).
    always_comb begin
        cur_clean = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == ch_q) cur_clean = clean_num[i*CNT_W +: CNT_W];
        end
        cur_crit = 32'(cur_clean) < CRIT_U;
    end

`ifdef GC_PREEMPT_EN
    assign preempt = host_req && !urg_q;
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        ch_d    = ch_q;
        urg_d   = urg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    ch_d    = sel_ch;
                    urg_d   = |crit;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A coincident move_done_flag is a stray and is dropped.
                if (gc_start) begin
                    cnt_d   = victim_pages;
                    state_d = (victim_pages == '0) ? CLEAN : MOVE;
                end
            end
            MOVE: begin
                if (move_done_flag) begin
                    cnt_d = cnt_q - PAGE_W'(1);
                    if (cnt_q == PAGE_W'(1)) begin
                        state_d = CLEAN;
                    end else if (preempt) begin
                        state_d = PAUSE;
                    end
                end
            end
            PAUSE: begin
                // Channel running out of blocks overrides the host.
                if (cur_crit) begin
                    urg_d   = 1'b1;
                    state_d = MOVE;
                end else if (!host_req) begin
                    state_d = MOVE;
                end
            end
            CLEAN: begin
                if (clean_done) state_d = DONE;
            end
            DONE: begin
                last_d  = ch_q;
                urg_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= CH_W'(NUM_CH - 1);
            ch_q    <= '0;
            urg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
            urg_q   <= urg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gc_request        = (state_q == REQ);
    assign move_flag         = (state_q == MOVE);
    assign request_blk_clean = (state_q == CLEAN);
    assign request_done      = (state_q == DONE);
    assign gc_ch             = ch_q;
    assign gc_urgent         = urg_q;
`ifdef GC_PREEMPT_EN
    assign gc_interrupt      = (state_q == PAUSE);
`else
    assign gc_interrupt      = 1'b0;
`endif

endmodule

// File: tb/tb_gc_sched_mc.sv
// tb_gc_sched_mc: directed self-checking bench for gc_sched_mc.
// Build with or without GC_PREEMPT_EN; expectations follow the macro.
module tb_gc_sched_mc;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] clean_num;
    logic        host_req;
    logic        gc_start;
    logic [5:0]  victim_pages;
    logic        move_done_flag;
    logic        clean_done;
    logic        gc_request;
    logic [1:0]  gc_ch;
    logic        gc_urgent;
    logic        move_flag;
    logic        request_blk_clean;
    logic        request_done;
    logic        gc_interrupt;

    int n_cmp = 0;
    int n_err = 0;

    gc_sched_mc dut (
        .CLK               (CLK),
        .RST               (RST),
        .clean_num         (clean_num),
        .host_req          (host_req),
        .gc_start          (gc_start),
        .victim_pages      (victim_pages),
        .move_done_flag    (move_done_flag),
        .clean_done        (clean_done),
        .gc_request        (gc_request),
        .gc_ch             (gc_ch),
        .gc_urgent         (gc_urgent),
        .move_flag         (move_flag),
        .request_blk_clean (request_blk_clean),
        .request_done      (request_done),
        .gc_interrupt      (gc_interrupt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] outs();
        return {gc_request, move_flag, request_blk_clean, request_done,
                gc_interrupt, gc_urgent, gc_ch};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [3:0] v);
        clean_num[ch*4 +: 4] = v;
    endtask

    task automatic wait_req(output logic ok);
        for (int i = 0; i < 20 && !gc_request; i++) tick();
        ok = gc_request;
    endtask

    task automatic pulse_move();
        move_done_flag = 1'b1;
        tick();
        move_done_flag = 1'b0;
    endtask

    // Runs one full pass, reporting what the DUT latched.
    task automatic do_pass(input logic [5:0] pages, output logic [1:0] ch,
                           output logic urg, output logic saw_move,
                           output logic ok);
        logic r;
        ok = 1'b0;
        saw_move = 1'b0;
        ch = '0;
        urg = 1'b0;
        wait_req(r);
        if (!r) return;
        ch = gc_ch;
        urg = gc_urgent;
        victim_pages = pages;
        gc_start = 1'b1;
        tick();
        gc_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (request_done) begin
                ok = 1'b1;
                break;
            end
            if (move_flag) begin
                saw_move = 1'b1;
                move_done_flag = 1'b1;
            end else if (request_blk_clean) begin
                clean_done = 1'b1;
            end
            tick();
            move_done_flag = 1'b0;
            clean_done = 1'b0;
        end
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        clean_num = {4{4'd8}};
        host_req = 0; gc_start = 0; victim_pages = 0;
        move_done_flag = 0; clean_done = 0;
        tick();
        n_cmp++;
        if (outs() !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outs got=%h exp=00", outs());
        end
        tick();
        RST = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_cmp++;
            if (outs() !== 8'h00) begin
                n_err++;
                $display("FAIL idle_quiet cyc=%0d got=%h exp=00", i, outs());
            end
        end
    endtask

    task automatic test_basic();
        logic r;
        set_ch(2, 4'd3);
        wait_req(r);
        n_cmp++;
        if (!r || gc_ch !== 2'd2 || gc_urgent !== 1'b0) begin
            n_err++;
            $display("FAIL basic_req got=%b/%0d/%b exp=1/2/0",
                     r, gc_ch, gc_urgent);
        end
        set_ch(2, 4'd8);
        victim_pages = 6'd3;
        gc_start = 1'b1;
        tick();
        gc_start = 1'b0;
        n_cmp++;
        if (gc_request !== 1'b0 || move_flag !== 1'b1) begin
            n_err++;
            $display("FAIL basic_start got=%b%b exp=01", gc_request, move_flag);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            pulse_move();
            n_cmp++;
            if (k < 3 && {move_flag, request_blk_clean} !== 2'b10) begin
                n_err++;
                $display("FAIL basic_mid k=%0d got=%b%b exp=10",
                         k, move_flag, request_blk_clean);
            end else if (k == 3 && {move_flag, request_blk_clean} !== 2'b01) begin
                n_err++;
                $display("FAIL basic_last got=%b%b exp=01",
                         move_flag, request_blk_clean);
            end
        end
        tick();
        clean_done = 1'b1;
        tick();
        clean_done = 1'b0;
        n_cmp++;
        if (request_done !== 1'b1 || request_blk_clean !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done got=%b exp=1", request_done);
        end
        tick();
        n_cmp++;
        if (outs() !== 8'h02) begin
            n_err++;
            $display("FAIL basic_idle got=%h exp=02", outs());
        end
    endtask

    task automatic test_priority();
        logic [1:0] ch;
        logic urg, sm, ok;
        set_ch(1, 4'd3);
        set_ch(3, 4'd0);
        do_pass(6'd1, ch, urg, sm, ok);
        n_cmp++;
        if (!ok || ch !== 2'd3 || urg !== 1'b1) begin
            n_err++;
            $display("FAIL prio_first got=%b/%0d/%b exp=1/3/1", ok, ch, urg);
        end
        n_cmp++;
        if (gc_urgent !== 1'b0) begin
            n_err++;
            $display("FAIL prio_urg_clr got=%b exp=0", gc_urgent);
        end
        set_ch(3, 4'd8);
        do_pass(6'd1, ch, urg, sm, ok);
        set_ch(1, 4'd8);
        n_cmp++;
        if (!ok || ch !== 2'd1 || urg !== 1'b0) begin
            n_err++;
            $display("FAIL prio_second got=%b/%0d/%b exp=1/1/0", ok, ch, urg);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] ch;
        logic urg, sm, ok;
        logic [5:0] pg [4] = '{6'd2, 6'd0, 6'd1, 6'd3};
        set_ch(0, 4'd2);
        set_ch(1, 4'd2);
        for (int p = 0; p < 4; p++) begin
            if (p == 3) begin
                set_ch(0, 4'd8);
            end
            do_pass(pg[p], ch, urg, sm, ok);
            n_cmp++;
            if (!ok || ch !== 2'(p % 2) || sm !== (pg[p] != 0)) begin
                n_err++;
                $display("FAIL rr pass=%0d got=%b/%0d/%b exp=1/%0d/%b",
                         p, ok, ch, sm, p % 2, pg[p] != 0);
            end
        end
        set_ch(1, 4'd8);
    endtask

    task automatic test_preempt();
        logic r;
        set_ch(2, 4'd3);
        wait_req(r);
        set_ch(2, 4'd8);
        victim_pages = 6'd4;
        gc_start = 1'b1;
        tick();
        gc_start = 1'b0;
        host_req = 1'b1;
        pulse_move();
`ifdef GC_PREEMPT_EN
        n_cmp++;
        if (!r || gc_interrupt !== 1'b1 || move_flag !== 1'b0) begin
            n_err++;
            $display("FAIL pre_pause got=%b%b exp=10", gc_interrupt, move_flag);
        end
        tick();
        tick();
        n_cmp++;
        if (gc_interrupt !== 1'b1) begin
            n_err++;
            $display("FAIL pre_hold got=%b exp=1", gc_interrupt);
        end
        host_req = 1'b0;
        tick();
        n_cmp++;
        if (gc_interrupt !== 1'b0 || move_flag !== 1'b1) begin
            n_err++;
            $display("FAIL pre_resume got=%b%b exp=01", gc_interrupt, move_flag);
        end
`else
        n_cmp++;
        if (!r || gc_interrupt !== 1'b0 || move_flag !== 1'b1) begin
            n_err++;
            $display("FAIL nopre_move got=%b%b exp=01", gc_interrupt, move_flag);
        end
        host_req = 1'b0;
`endif
        for (int k = 1; k <= 3; k++) begin
            pulse_move();
            n_cmp++;
            if (k < 3 && {move_flag, request_blk_clean} !== 2'b10) begin
                n_err++;
                $display("FAIL pre_rest k=%0d got=%b%b exp=10",
                         k, move_flag, request_blk_clean);
            end else if (k == 3 && {move_flag, request_blk_clean} !== 2'b01) begin
                n_err++;
                $display("FAIL pre_last got=%b%b exp=01",
                         move_flag, request_blk_clean);
            end
        end
        clean_done = 1'b1;
        tick();
        clean_done = 1'b0;
        tick();
`ifdef GC_PREEMPT_EN
        // Channel goes critical while paused: resume as urgent, no re-pause.
        set_ch(2, 4'd3);
        wait_req(r);
        victim_pages = 6'd3;
        gc_start = 1'b1;
        tick();
        gc_start = 1'b0;
        host_req = 1'b1;
        pulse_move();
        set_ch(2, 4'd0);
        tick();
        n_cmp++;
        if (!r || move_flag !== 1'b1 || gc_urgent !== 1'b1) begin
            n_err++;
            $display("FAIL pre_crit got=%b%b exp=11", move_flag, gc_urgent);
        end
        set_ch(2, 4'd8);
        pulse_move();
        n_cmp++;
        if (move_flag !== 1'b1 || gc_interrupt !== 1'b0) begin
            n_err++;
            $display("FAIL pre_urg_nopause got=%b%b exp=10",
                     move_flag, gc_interrupt);
        end
        pulse_move();
        host_req = 1'b0;
        clean_done = 1'b1;
        tick();
        clean_done = 1'b0;
        tick();
`endif
    endtask

    task automatic test_stray();
        logic r;
        gc_start = 1; move_done_flag = 1; clean_done = 1;
        tick();
        tick();
        gc_start = 0; move_done_flag = 0; clean_done = 0;
        n_cmp++;
        if (outs() !== 8'h02) begin
            n_err++;
            $display("FAIL stray_idle got=%h exp=02", outs());
        end
        set_ch(0, 4'd3);
        wait_req(r);
        set_ch(0, 4'd8);
        victim_pages = 6'd1;
        gc_start = 1'b1;
        move_done_flag = 1'b1;
        tick();
        gc_start = 1'b0;
        move_done_flag = 1'b0;
        clean_done = 1'b1;
        tick();
        clean_done = 1'b0;
        n_cmp++;
        if (!r || gc_ch !== 2'd0 || {move_flag, request_blk_clean} !== 2'b10) begin
            n_err++;
            $display("FAIL stray_req_move got=%0d/%b%b exp=0/10",
                     gc_ch, move_flag, request_blk_clean);
        end
        pulse_move();
        gc_start = 1'b1;
        move_done_flag = 1'b1;
        tick();
        gc_start = 1'b0;
        move_done_flag = 1'b0;
        n_cmp++;
        if (request_blk_clean !== 1'b1 || request_done !== 1'b0) begin
            n_err++;
            $display("FAIL stray_clean got=%b%b exp=10",
                     request_blk_clean, request_done);
        end
        clean_done = 1'b1;
        tick();
        clean_done = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic r, urg, sm, ok;
        logic [1:0] ch;
        set_ch(3, 4'd3);
        wait_req(r);
        victim_pages = 6'd5;
        gc_start = 1'b1;
        tick();
        gc_start = 1'b0;
        pulse_move();
        n_cmp++;
        if (!r || gc_ch !== 2'd3 || move_flag !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre got=%0d/%b exp=3/1", gc_ch, move_flag);
        end
        set_ch(3, 4'd8);
        RST = 1'b1;
        tick();
        n_cmp++;
        if (outs() !== 8'h00) begin
            n_err++;
            $display("FAIL rstmid_outs got=%h exp=00", outs());
        end
        RST = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (request_done !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_nodone got=%b exp=0", request_done);
        end
        set_ch(0, 4'd3);
        set_ch(3, 4'd3);
        do_pass(6'd1, ch, urg, sm, ok);
        n_cmp++;
        if (!ok || ch !== 2'd0) begin
            n_err++;
            $display("FAIL rstmid_restart got=%b/%0d exp=1/0", ok, ch);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_round_robin();
        test_preempt();
        test_stray();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
